pipelined_adder: RTL and testbench

- Parametrised WIDTH-bit adder/subtractor, split into STAGES ripple-carry chunks with a register between chunks.
- Throughput is one operation per cycle. Results appear in issue order.
- Valid/ready handshake on both sides, with global stall.
- Feeds the pipelined ALU path. Replaces single-cycle ripple carry on wide operands, so the carry chain is cut to WIDTH/STAGES bits per cycle.

---
 rtl/pipelined_adder_pkg.sv | 23 ++
 rtl/pipelined_adder_chunk.sv | 31 +++
 rtl/pipelined_adder.sv | 140 ++++++++++++++
 tb/tb_pipelined_adder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: mode encodings, default
// geometry and the single-bit full-adder cell used by every chunk.
package pipelined_adder_pkg;

    localparam logic ADD_MODE       = 1'b0;
    localparam logic SUB_MODE       = 1'b1;
    localparam int   DEFAULT_WIDTH  = 32;
    localparam int   DEFAULT_STAGES = 4;

    typedef struct packed {
        logic s;
        logic co;
    } fa_t;

    // One-bit full adder: sum and majority carry.
    function automatic fa_t full_add(input logic a, input logic b, input logic ci);
        fa_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (a & ci) | (b & ci);
        return r;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CW-bit ripple-carry chunk built from full-adder cells.
// c_msb is the carry into the chunk's top bit; the top chunk uses it to
// form the signed-overflow flag.
module adder_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [CW:0] c_s;
    fa_t         fa_s [CW];

    assign c_s[0] = ci;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        assign fa_s[i]   = full_add(a[i], b[i], c_s[i]);
        assign s[i]      = fa_s[i].s;
        assign c_s[i+1]  = fa_s[i].co;
    end

    assign co    = c_s[CW];
    assign c_msb = c_s[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor cut into STAGES ripple-carry chunks with a
// register after each chunk. Every stage carries the full operands and the
// partial sum; stage k fills in chunk k using the carry registered by
// stage k-1. The whole pipe advances together when the output slot is
// free or being consumed, so results leave in issue order with no loss.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic              adv_s;

    // Per-stage registers and their next-state values.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q,  cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    // What each stage sees at its input.
    logic [WIDTH-1:0]  a_in_s [STAGES];
    logic [WIDTH-1:0]  b_in_s [STAGES];
    logic [WIDTH-1:0]  s_in_s [STAGES];
    logic [STAGES-1:0] ci_s;
    logic [STAGES-1:0] v_in_s;
    logic [STAGES-1:0] co_s;
    logic [CW-1:0]     cs_s [STAGES];
    logic              top_cmsb_s;

    assign adv_s     = !reset && (!out_valid || out_ready);
    assign in_ready  = adv_s;

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = ovf_q;

    // Stage inputs: stage 0 takes the (mode-adjusted) operands, later stages
    // take their predecessor's registers.
    always_comb begin
        a_in_s[0] = a;
        b_in_s[0] = (sub == SUB_MODE) ? ~b : b;
        ci_s[0]   = (sub == SUB_MODE) ? 1'b1 : cin;
        s_in_s[0] = '0;
        v_in_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in_s[k] = a_q[k-1];
            b_in_s[k] = b_q[k-1];
            ci_s[k]   = cy_q[k-1];
            s_in_s[k] = s_q[k-1];
            v_in_s[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == STAGES - 1) begin : g_top
            adder_chunk #(.CW(CW)) u_chunk (
                .a     (a_in_s[k][k*CW +: CW]),
                .b     (b_in_s[k][k*CW +: CW]),
                .ci    (ci_s[k]),
                .s     (cs_s[k]),
                .co    (co_s[k]),
                .c_msb (top_cmsb_s)
            );
        end else begin : g_mid
            logic unused_cmsb_s;
            adder_chunk #(.CW(CW)) u_chunk (
                .a     (a_in_s[k][k*CW +: CW]),
                .b     (b_in_s[k][k*CW +: CW]),
                .ci    (ci_s[k]),
                .s     (cs_s[k]),
                .co    (co_s[k]),
                .c_msb (unused_cmsb_s)
            );
        end
    end

    // Next-state: forward operands, splice this stage's chunk into the sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = v_in_s[k];
            cy_d[k]  = co_s[k];
            a_d[k]   = a_in_s[k];
            b_d[k]   = b_in_s[k];
            s_d[k]   = s_in_s[k];
            s_d[k][k*CW +: CW] = cs_s[k];
        end
        ovf_d = top_cmsb_s ^ co_s[STAGES-1];
    end

    // Pipeline registers: clear on reset, shift together on advance, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv_s) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (4, 1 and 8 stages) share the
// operand stream; each is tracked by a queue scoreboard fed from an
// arithmetic reference model, plus directed checks from the test plan.
module tb_pipelined_adder;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic [31:0]  cyc;
        logic [31:0]  stl;
    } exp_t;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         sub       = 1'b0;
    logic         cin       = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         iv_g;

    logic         rdy [3];
    logic         ov  [3];
    logic [W-1:0] sm  [3];
    logic         co  [3];
    logic         of  [3];

    int           checks_cnt = 0;
    int           fail_cnt   = 0;
    int           cyc        = 0;
    int           stl  [3]   = '{0, 0, 0};
    int           pops [3]   = '{0, 0, 0};
    int           s_of [3]   = '{4, 1, 8};
    logic         hold_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [34:0]  hold_val [3];
    exp_t         sbq [3][$];

    always #5 clk = ~clk;

    assign iv_g = in_valid && rdy[0];

    pipelined_adder #(.WIDTH(W), .STAGES(4)) u_s4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm[0]), .cout(co[0]), .ovf(of[0]));

    pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(iv_g), .in_ready(rdy[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[1]), .out_ready(1'b1),
        .sum(sm[1]), .cout(co[1]), .ovf(of[1]));

    pipelined_adder #(.WIDTH(W), .STAGES(8)) u_s8 (
        .clk(clk), .reset(reset), .in_valid(iv_g), .in_ready(rdy[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[2]), .out_ready(1'b1),
        .sum(sm[2]), .cout(co[2]), .ovf(of[2]));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain arithmetic on the full width.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic msub, input logic mcin);
        logic [W-1:0] be;
        logic [W:0]   t;
        logic         c0;
        logic         o;
        be = msub ? ~mb : mb;
        c0 = msub ? 1'b1 : mcin;
        t  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c0};
        o  = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
        return {o, t};
    endfunction

    task automatic mon(input int id);
        logic         ordy;
        logic         iv;
        exp_t         e;
        logic [W+1:0] m;
        int           lat_exp;
        ordy = (id == 0) ? out_ready : 1'b1;
        iv   = (id == 0) ? in_valid  : iv_g;
        check_val($sformatf("in_ready[%0d]", id), 64'(rdy[id]), 64'(!reset && (!ov[id] || ordy)));
        if (reset) begin
            sbq[id].delete();
            hold_v[id] = 1'b0;
        end else begin
            if (hold_v[id]) begin
                check_val($sformatf("hold[%0d]", id), 64'({ov[id], of[id], co[id], sm[id]}),
                          64'(hold_val[id]));
            end
            if (ov[id] && ordy) begin
                check_val($sformatf("pop_expected[%0d]", id), 64'(sbq[id].size() != 0), 64'(1));
                if (sbq[id].size() != 0) begin
                    e = sbq[id].pop_front();
                    pops[id]++;
                    lat_exp = s_of[id] + (stl[id] - int'(e.stl));
                    check_val($sformatf("sum[%0d]", id), 64'(sm[id]), 64'(e.s));
                    check_val($sformatf("cout[%0d]", id), 64'(co[id]), 64'(e.c));
                    check_val($sformatf("ovf[%0d]", id), 64'(of[id]), 64'(e.o));
                    check_val($sformatf("latency[%0d]", id), 64'(cyc - int'(e.cyc)), 64'(lat_exp));
                end
            end
            if (ov[id] && !ordy) begin
                stl[id]++;
                hold_v[id]   = 1'b1;
                hold_val[id] = {ov[id], of[id], co[id], sm[id]};
            end else begin
                hold_v[id] = 1'b0;
            end
            if (iv && rdy[id]) begin
                m     = model(a, b, sub, cin);
                e.s   = m[W-1:0];
                e.c   = m[W];
                e.o   = m[W+1];
                e.cyc = 32'(cyc);
                e.stl = 32'(stl[id]);
                sbq[id].push_back(e);
            end
        end
    endtask

    // Scoreboard sampling, away from the rising edge.
    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) mon(id);
        cyc++;
    end

    // Present one operation and hold it until accepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input logic tc);
        int n;
        n = 0;
        a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        while (!rdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("send_ready", 64'(rdy[0]), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic ts, input logic tc, input logic [W-1:0] es,
                           input logic ec, input logic eo);
        int n;
        send(ta, tb_, ts, tc);
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_valid"}, 64'(ov[0]), 64'(1));
        check_val({tag, "_sum"},   64'(sm[0]), 64'(es));
        check_val({tag, "_cout"},  64'(co[0]), 64'(ec));
        check_val({tag, "_ovf"},   64'(of[0]), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          p0;
        int          p2;
        logic [3:0]  pat;

        // Reset for two edges; check cleared outputs on all instances.
        @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check_val($sformatf("rst_valid[%0d]", id), 64'(ov[id]), 64'(0));
            check_val($sformatf("rst_sum[%0d]", id), 64'(sm[id]), 64'(0));
            check_val($sformatf("rst_flags[%0d]", id), 64'({co[id], of[id]}), 64'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 1: exact latency on the 4-stage instance.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            if (e > 1) @(posedge clk);
            @(negedge clk);
            check_val($sformatf("t1_valid_edge%0d", e), 64'(ov[0]), 64'(e == 4));
        end
        check_val("t1_sum",  64'(sm[0]), 64'(32'h0000_0100));
        check_val("t1_cout", 64'(co[0]), 64'(0));
        check_val("t1_ovf",  64'(of[0]), 64'(0));
        @(posedge clk);
        #1;

        // Test 2 and 3: carry ripple, overflow, subtract.
        run_vec("t2_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_vec("t2_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_vec("t3_sub",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec("t3_subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_vec("t3_subcin", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec("t3_ovfcin", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Test 4: eight back-to-back ops with a 3-cycle output stall.
        p0 = pops[0];
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i), 32'(16 * i), 1'b0, 1'b0);
            end
            begin
                n = 0;
                while (!ov[0] && n < 40) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check_val("t4_first", 64'(ov[0]), 64'(1));
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_val("t4_stall_ready", 64'(rdy[0]), 64'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        check_val("t4_count", 64'(pops[0] - p0), 64'(8));
        check_val("t4_drained", 64'(sbq[0].size()), 64'(0));

        // Test 5: bubbles propagate unchanged.
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            in_valid = pat[i];
            a = 32'(100 + i); b = 32'(7 * i); sub = 1'b0; cin = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_val("t5_valid0", 64'(ov[0]), 64'(pat[0]));
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("t5_valid%0d", i), 64'(ov[0]), 64'(pat[i]));
        end
        repeat (4) @(posedge clk);
        #1;

        // Test 6: reset with three operations in flight.
        for (int i = 0; i < 3; i++) send(32'(1000 + i), 32'(3 * i), 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check_val($sformatf("t6_valid[%0d]", id), 64'(ov[id]), 64'(0));
        end
        p0 = pops[0];
        p2 = pops[2];
        repeat (10) @(posedge clk);
        #1;
        check_val("t6_nopop4", 64'(pops[0] - p0), 64'(0));
        check_val("t6_nopop8", 64'(pops[2] - p2), 64'(0));
        run_vec("t6_after", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Random traffic with random back-pressure on the 4-stage instance.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            sub       = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            check_val($sformatf("final_drained[%0d]", id), 64'(sbq[id].size()), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
